// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead add/sub unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cla_pkg;

   localparam int CLA_WIDTH  = 32;
   localparam int CLA_STAGES = 2;
   localparam int CLA_GROUP  = 4;

   // Number of result bits each pipeline stage resolves.
   function automatic int slice_width(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit adder built from GROUP-bit lookahead blocks chained by group carry.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline stage register decides when the result is captured.
module cla_slice #(
   parameter int SLICE = 16,
   parameter int GROUP = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] sum,
   output logic             cout
);

   localparam int NGRP = SLICE / GROUP;

   logic [SLICE-1:0] gen;
   logic [SLICE-1:0] prop;

   assign gen  = a & b;
   assign prop = a ^ b;

   // Per group: flat two-level lookahead for each bit carry, then group G/P to feed the next group.
   always_comb begin
      logic cg;
      logic cbit;
      logic term;
      logic grp_g;
      logic grp_p;
      sum   = '0;
      cg    = cin;
      cbit  = 1'b0;
      term  = 1'b0;
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int k = 0; k < NGRP; k++) begin
         for (int j = 0; j < GROUP; j++) begin
            // carry into bit j = cg & p[0..j-1]  |  OR_i ( g[i] & p[i+1..j-1] )
            cbit = cg;
            for (int i = 0; i < j; i++) begin
               cbit = cbit & prop[k*GROUP+i];
            end
            for (int i = 0; i < j; i++) begin
               term = gen[k*GROUP+i];
               for (int m = i + 1; m < j; m++) begin
                  term = term & prop[k*GROUP+m];
               end
               cbit = cbit | term;
            end
            sum[k*GROUP+j] = prop[k*GROUP+j] ^ cbit;
         end
         grp_g = 1'b0;
         grp_p = 1'b1;
         for (int i = 0; i < GROUP; i++) begin
            grp_g = gen[k*GROUP+i] | (prop[k*GROUP+i] & grp_g);
            grp_p = grp_p & prop[k*GROUP+i];
         end
         cg = grp_g | (grp_p & cg);
      end
      cout = cg;
   end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined add/sub: each stage resolves WIDTH/STAGES result bits, operands skewed forward; optional overflow via PIPELINED_CLA_OVF_EN.
// Latency: exactly STAGES cycles from input transfer to o_valid when not stalled.
// Backpressure: whole pipe advances on i_ready | ~o_valid; o_ready mirrors that enable, so a stalled full pipe holds everything.
module pipelined_cla_addsub
   import cla_pkg::*;
#(
   parameter int WIDTH  = CLA_WIDTH,
   parameter int STAGES = CLA_STAGES,
   parameter int GROUP  = CLA_GROUP
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_add1,
   input  logic [WIDTH-1:0] i_add2,
   input  logic             i_sub,
   input  logic             i_carry,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH:0]   o_result,
   output logic             o_overflow
);

   localparam int SL = slice_width(WIDTH, STAGES);

   // Reject illegal geometry at elaboration rather than building a wrong adder.
   if (WIDTH < 4 || WIDTH > 64 || STAGES < 1 || STAGES > 4 ||
       (WIDTH % STAGES) != 0 || (SL % GROUP) != 0) begin : g_bad_param
      $error("pipelined_cla_addsub: illegal WIDTH/STAGES/GROUP combination");
   end

   logic advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_in, b_in, s_in, s_nx;
      logic [WIDTH-1:0] a_q, b_q, s_q;
      logic             c_in, v_in, c_q, v_q;
      logic [SL-1:0]    sl_sum;
      logic             sl_cout;

      if (k == 0) begin : g_first
         // Subtraction folds into the adder as A + ~B + 1.
         assign a_in = i_add1;
         assign b_in = i_sub ? ~i_add2 : i_add2;
         assign c_in = i_sub | i_carry;
         assign s_in = '0;
         assign v_in = i_valid;
      end else begin : g_next
         assign a_in = g_stage[k-1].a_q;
         assign b_in = g_stage[k-1].b_q;
         assign c_in = g_stage[k-1].c_q;
         assign s_in = g_stage[k-1].s_q;
         assign v_in = g_stage[k-1].v_q;
      end

      cla_slice #(.SLICE(SL), .GROUP(GROUP)) u_slice (
         .a    (a_in[k*SL +: SL]),
         .b    (b_in[k*SL +: SL]),
         .cin  (c_in),
         .sum  (sl_sum),
         .cout (sl_cout)
      );

      // Splice this stage's resolved bits into the partial sum carried down the pipe.
      always_comb begin
         s_nx = s_in;
         s_nx[k*SL +: SL] = sl_sum;
      end

      // Stage register: cleared on reset, shifts only when the whole pipe advances.
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            v_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            c_q <= 1'b0;
         end else if (advance) begin
            v_q <= v_in;
            a_q <= a_in;
            b_q <= b_in;
            s_q <= s_nx;
            c_q <= sl_cout;
         end
      end
   end

   assign o_valid  = g_stage[STAGES-1].v_q;
   assign advance  = i_ready | ~o_valid;
   assign o_ready  = advance;
   assign o_result = {g_stage[STAGES-1].c_q, g_stage[STAGES-1].s_q};

`ifdef PIPELINED_CLA_OVF_EN
   logic ovf_q;

   // Overflow is resolved alongside the top slice and captured with its result.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ovf_q <= 1'b0;
      end else if (advance) begin
         ovf_q <= (g_stage[STAGES-1].a_in[WIDTH-1] == g_stage[STAGES-1].b_in[WIDTH-1]) &
                  (g_stage[STAGES-1].s_nx[WIDTH-1] != g_stage[STAGES-1].a_in[WIDTH-1]);
      end
   end

   assign o_overflow = ovf_q;
`else
   assign o_overflow = 1'b0;
`endif

endmodule
